// File: rtl/game_sequencer.sv
// ---------------------------------------------------------------------------
// game_sequencer
//
// Top-level game-flow controller for a block-breaker game. It tracks the game
// phase (idle, serve, play, miss, level clear, game over), keeps lives and a
// saturating score, and drives the ball and collision-detector control pulses.
// All outputs are registered and change one pclk after the causing event.
//
// Optional feature (compile-time macro SERVE_AUTO_EN):
//   when defined, SERVE also advances to PLAY after SERVE_FRAMES frame_tick
//   pulses counted from SERVE entry; otherwise frame_tick is ignored.
//
// Ports:
//   pclk        in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   frame_tick  in   one-pclk pulse per video frame
//   start_btn   in   debounced player button (level)
//   ball_y      in   [11:0] current ball top coordinate
//   coll_in     in   collision indication (level)
//   blocks_in   in   [15:0] destroyed-tile bitmap, bit set = tile gone
//   state       out  [2:0] current state code
//   ball_run    out  ball motion enable
//   ball_serve  out  one-cycle pulse: reposition ball at the paddle
//   det_clear   out  one-cycle pulse: clear collision detector bitmap/counters
//   lives       out  [1:0] remaining lives
//   score       out  [15:0] saturating score
//   game_over   out  high while in OVER
// ---------------------------------------------------------------------------
module game_sequencer #(
    parameter int unsigned LIVES_INIT   = 3,
    parameter int unsigned BOTTOM_Y     = 756,
    parameter int unsigned SERVE_FRAMES = 60
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        start_btn,
    input  logic [11:0] ball_y,
    input  logic        coll_in,
    input  logic [15:0] blocks_in,
    output logic [2:0]  state,
    output logic        ball_run,
    output logic        ball_serve,
    output logic        det_clear,
    output logic [1:0]  lives,
    output logic [15:0] score,
    output logic        game_over
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StServe = 3'd1,
        StPlay  = 3'd2,
        StMiss  = 3'd3,
        StClear = 3'd4,
        StOver  = 3'd5
    } state_e;

    state_e      state_q, state_d;
    logic        btn_q, coll_q;
    logic        btn_armed_q;
    logic [1:0]  lives_q, lives_d;
    logic [15:0] score_q, score_d;
    logic        ball_run_q, ball_serve_q, det_clear_q, game_over_q;
    logic        ball_run_d, ball_serve_d, det_clear_d, game_over_d;

    logic        btn_edge, coll_edge;
    logic        auto_go;
    logic        score_clr;
    logic [4:0]  score_inc;
    logic [16:0] score_sum;

    // btn_armed_q stays low while the button is held through reset, so a held
    // button cannot start a game until it has been released once.
    assign btn_edge  = start_btn & ~btn_q & btn_armed_q;
    assign coll_edge = coll_in & ~coll_q;

`ifdef SERVE_AUTO_EN
    logic [7:0] frame_cnt_q, frame_cnt_d;

    assign auto_go = (state_q == StServe) && frame_tick &&
                     (frame_cnt_q == 8'(SERVE_FRAMES - 1));

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (state_d == StServe && state_q != StServe) begin
            frame_cnt_d = 8'd0;
        end else if (state_q == StServe && frame_tick) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            frame_cnt_q <= 8'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end
`else
    logic unused_frame_tick;

    assign auto_go           = 1'b0;
    assign unused_frame_tick = frame_tick ^ (SERVE_FRAMES == 0);
`endif

    always_comb begin
        state_d   = state_q;
        lives_d   = lives_q;
        score_inc = 5'd0;
        score_clr = 1'b0;

        case (state_q)
            StIdle: begin
                if (btn_edge) begin
                    state_d   = StServe;
                    lives_d   = 2'(LIVES_INIT);
                    score_clr = 1'b1;
                end
            end
            StServe: begin
                if (btn_edge || auto_go) begin
                    state_d = StPlay;
                end
            end
            StPlay: begin
                // A collision on the exit cycle is still scored.
                score_inc = {4'd0, coll_edge};
                if (blocks_in == 16'hFFFF) begin
                    state_d   = StClear;
                    score_inc = 5'd16 + {4'd0, coll_edge};
                end else if (ball_y >= 12'(BOTTOM_Y)) begin
                    state_d = StMiss;
                    if (lives_q != 2'd0) begin
                        lives_d = lives_q - 2'd1;
                    end
                end
            end
            StMiss: begin
                // lives already decremented on entry into MISS
                state_d = (lives_q == 2'd0) ? StOver : StServe;
            end
            StClear: begin
                state_d = StServe;
            end
            StOver: begin
                if (btn_edge) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        score_sum = {1'b0, score_q} + {12'd0, score_inc};
        if (score_clr) begin
            score_d = 16'd0;
        end else if (score_sum[16]) begin
            score_d = 16'hFFFF;
        end else begin
            score_d = score_sum[15:0];
        end

        ball_serve_d = (state_d == StServe) && (state_q != StServe);
        det_clear_d  = ((state_q == StIdle) && (state_d == StServe)) ||
                       ((state_d == StClear) && (state_q != StClear));
        ball_run_d   = (state_d == StPlay);
        game_over_d  = (state_d == StOver);
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q      <= StIdle;
            btn_q        <= 1'b0;
            coll_q       <= 1'b0;
            btn_armed_q  <= ~start_btn;
            lives_q      <= 2'd0;
            score_q      <= 16'd0;
            ball_run_q   <= 1'b0;
            ball_serve_q <= 1'b0;
            det_clear_q  <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            btn_q        <= start_btn;
            coll_q       <= coll_in;
            btn_armed_q  <= btn_armed_q | ~start_btn;
            lives_q      <= lives_d;
            score_q      <= score_d;
            ball_run_q   <= ball_run_d;
            ball_serve_q <= ball_serve_d;
            det_clear_q  <= det_clear_d;
            game_over_q  <= game_over_d;
        end
    end

    assign state      = state_q;
    assign ball_run   = ball_run_q;
    assign ball_serve = ball_serve_q;
    assign det_clear  = det_clear_q;
    assign lives      = lives_q;
    assign score      = score_q;
    assign game_over  = game_over_q;

endmodule

// File: tb/tb_game_sequencer.sv
// ---------------------------------------------------------------------------
// tb_game_sequencer
//
// Self-checking bench for game_sequencer: directed scenarios for the game
// flow plus a randomized phase, all compared cycle by cycle against a
// behavioural game model. Honours SERVE_AUTO_EN when defined.
// ---------------------------------------------------------------------------
module tb_game_sequencer;

    localparam int unsigned LivesInit   = 3;
    localparam int unsigned BottomY     = 756;
    localparam int unsigned ServeFrames = 60;

    logic        pclk = 1'b0;
    logic        rst;
    logic        frame_tick;
    logic        start_btn;
    logic [11:0] ball_y;
    logic        coll_in;
    logic [15:0] blocks_in;
    logic [2:0]  state;
    logic        ball_run;
    logic        ball_serve;
    logic        det_clear;
    logic [1:0]  lives;
    logic [15:0] score;
    logic        game_over;

    int n_checks = 0;
    int n_errors = 0;

    // behavioural model of the game
    int m_st;
    int m_lives;
    int m_score;
    int m_ticks;
    bit m_run, m_serve, m_clr, m_over;
    bit m_pbtn, m_pcoll, m_armed;

    game_sequencer #(
        .LIVES_INIT  (LivesInit),
        .BOTTOM_Y    (BottomY),
        .SERVE_FRAMES(ServeFrames)
    ) dut (
        .pclk      (pclk),
        .rst       (rst),
        .frame_tick(frame_tick),
        .start_btn (start_btn),
        .ball_y    (ball_y),
        .coll_in   (coll_in),
        .blocks_in (blocks_in),
        .state     (state),
        .ball_run  (ball_run),
        .ball_serve(ball_serve),
        .det_clear (det_clear),
        .lives     (lives),
        .score     (score),
        .game_over (game_over)
    );

    always #5 pclk = ~pclk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock of game rules applied to the inputs present at the edge.
    task automatic model_step();
        bit bedge, cedge;
        int nxt, add;
        if (rst) begin
            m_st = 0; m_lives = 0; m_score = 0; m_ticks = 0;
            m_run = 0; m_serve = 0; m_clr = 0; m_over = 0;
            m_pbtn = 0; m_pcoll = 0;
            m_armed = !start_btn;
            return;
        end
        bedge = start_btn && !m_pbtn && m_armed;
        cedge = coll_in && !m_pcoll;
        if (!start_btn) m_armed = 1;
        m_pbtn  = start_btn;
        m_pcoll = coll_in;
        nxt     = m_st;
        m_serve = 0;
        m_clr   = 0;
        case (m_st)
            0: if (bedge) begin
                m_lives = LivesInit; m_score = 0; m_clr = 1; nxt = 1;
            end
            1: begin
`ifdef SERVE_AUTO_EN
                if (frame_tick) m_ticks++;
                if (m_ticks == ServeFrames) nxt = 2;
`endif
                if (bedge) nxt = 2;
            end
            2: begin
                add = cedge ? 1 : 0;
                if (blocks_in == 16'hFFFF) begin
                    add += 16; m_clr = 1; nxt = 4;
                end else if (int'(ball_y) >= BottomY) begin
                    if (m_lives > 0) m_lives--;
                    nxt = 3;
                end
                m_score = (m_score + add > 65535) ? 65535 : m_score + add;
            end
            3: nxt = (m_lives == 0) ? 5 : 1;
            4: nxt = 1;
            5: if (bedge) nxt = 0;
            default: nxt = 0;
        endcase
        if (nxt == 1 && m_st != 1) begin
            m_serve = 1;
            m_ticks = 0;
        end
        m_st   = nxt;
        m_run  = (nxt == 2);
        m_over = (nxt == 5);
    endtask

    task automatic compare_all();
        check_eq("state", 32'(state), 32'(m_st));
        check_eq("ball_run", 32'(ball_run), 32'(m_run));
        check_eq("ball_serve", 32'(ball_serve), 32'(m_serve));
        check_eq("det_clear", 32'(det_clear), 32'(m_clr));
        check_eq("lives", 32'(lives), 32'(m_lives));
        check_eq("score", 32'(score), 32'(m_score));
        check_eq("game_over", 32'(game_over), 32'(m_over));
    endtask

    task automatic cyc();
        @(posedge pclk);
        model_step();
        #1;
        compare_all();
    endtask

    // release then press; leaves the button held
    task automatic press();
        start_btn = 1'b0;
        cyc();
        start_btn = 1'b1;
        cyc();
    endtask

    task automatic idle_inputs();
        frame_tick = 1'b0; start_btn = 1'b0; coll_in = 1'b0;
        ball_y = 12'd0; blocks_in = 16'd0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        start_btn = 1'b1;
        repeat (3) cyc();
        check_eq("rst_state", 32'(state), 32'd0);
        check_eq("rst_score", 32'(score), 32'd0);
        rst = 1'b0;
        // button held through reset must not start a game
        repeat (3) cyc();
        check_eq("held_btn_no_start", 32'(state), 32'd0);

        // start: single det_clear and ball_serve
        press();
        check_eq("start_state", 32'(state), 32'd1);
        check_eq("start_lives", 32'(lives), 32'd3);
        check_eq("start_det_clear", 32'(det_clear), 32'd1);
        check_eq("start_serve", 32'(ball_serve), 32'd1);
        start_btn = 1'b0;
        cyc();
        check_eq("serve_pulse_end", 32'({ball_serve, det_clear, ball_run}), 32'd0);
        start_btn = 1'b1;
        cyc();
        check_eq("play_state", 32'(state), 32'd2);
        check_eq("play_run", 32'(ball_run), 32'd1);
        start_btn = 1'b0;

        // five collisions, one held for 10 cycles
        for (int i = 0; i < 4; i++) begin
            coll_in = 1'b1; cyc();
            coll_in = 1'b0; cyc();
        end
        coll_in = 1'b1;
        repeat (10) cyc();
        coll_in = 1'b0;
        cyc();
        check_eq("score_5", 32'(score), 32'd5);

        // level clear wins over a simultaneous miss
        blocks_in = 16'hFFFF; ball_y = 12'd800;
        cyc();
        check_eq("clear_state", 32'(state), 32'd4);
        check_eq("clear_score", 32'(score), 32'd21);
        check_eq("clear_det", 32'(det_clear), 32'd1);
        check_eq("clear_lives", 32'(lives), 32'd3);
        blocks_in = 16'd0; ball_y = 12'd0;
        cyc();
        check_eq("clear_to_serve", 32'(state), 32'd1);

        // three misses end the game
        for (int i = 0; i < 3; i++) begin
            press();
            start_btn = 1'b0;
            ball_y = 12'd756;
            cyc();
            check_eq("miss_state", 32'(state), 32'd3);
            check_eq("miss_lives", 32'(lives), 32'(2 - i));
            ball_y = 12'd0;
            cyc();
            check_eq("after_miss", 32'(state), (i < 2) ? 32'd1 : 32'd5);
        end
        check_eq("over_flag", 32'(game_over), 32'd1);
        check_eq("over_score_held", 32'(score), 32'd21);
        press();
        check_eq("over_to_idle", 32'(state), 32'd0);

        // reset mid-PLAY overrides a simultaneous collision and miss
        press();
        press();
        start_btn = 1'b0;
        check_eq("pre_rst_play", 32'(state), 32'd2);
        rst = 1'b1; coll_in = 1'b1; ball_y = 12'd800;
        cyc();
        check_eq("midrst_outs",
                 32'({state, ball_run, ball_serve, det_clear, lives, game_over}), 32'd0);
        check_eq("midrst_score", 32'(score), 32'd0);
        rst = 1'b0;
        idle_inputs();
        cyc();

        // randomized play against the model
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 299) == 0);
            frame_tick = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) == 0) start_btn = ~start_btn;
            if ($urandom_range(0, 2) == 0) coll_in = ~coll_in;
            case ($urandom_range(0, 29))
                0: ball_y = 12'($urandom_range(BottomY, 4095));
                1: ball_y = 12'd755;
                2: ball_y = 12'd756;
                default: ball_y = 12'($urandom_range(0, BottomY - 1));
            endcase
            blocks_in = ($urandom_range(0, 49) == 0) ? 16'hFFFF : 16'($urandom & 32'hFFFE);
            cyc();
        end

        // drive score to saturation via repeated level clears
        idle_inputs();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        press();
        start_btn = 1'b0;
        cyc();
        for (int i = 0; i < 4095; i++) begin
            start_btn = 1'b1; cyc();
            start_btn = 1'b0; blocks_in = 16'hFFFF; cyc();
            blocks_in = 16'd0; cyc();
        end
        check_eq("score_fff0", 32'(score), 32'h0000FFF0);
        start_btn = 1'b1; cyc();
        start_btn = 1'b0;
        for (int i = 0; i < 5; i++) begin
            coll_in = 1'b1; cyc();
            coll_in = 1'b0; cyc();
        end
        check_eq("score_fff5", 32'(score), 32'h0000FFF5);
        blocks_in = 16'hFFFF; cyc();
        check_eq("score_sat", 32'(score), 32'h0000FFFF);
        blocks_in = 16'd0; cyc();
        start_btn = 1'b1; cyc();
        start_btn = 1'b0; blocks_in = 16'hFFFF; coll_in = 1'b1; cyc();
        check_eq("score_sat_hold", 32'(score), 32'h0000FFFF);
        check_eq("sat_lives", 32'(lives), 32'd3);
        idle_inputs();
        cyc();

`ifdef SERVE_AUTO_EN
        // auto-serve after ServeFrames ticks without a press
        rst = 1'b1; cyc();
        rst = 1'b0;
        press();
        start_btn = 1'b0;
        for (int i = 1; i <= int'(ServeFrames); i++) begin
            frame_tick = 1'b1; cyc();
            if (i == int'(ServeFrames) - 1) check_eq("auto_pre", 32'(state), 32'd1);
            frame_tick = 1'b0;
            if (i < int'(ServeFrames)) cyc();
        end
        check_eq("auto_play", 32'(state), 32'd2);
        check_eq("auto_run", 32'(ball_run), 32'd1);
        rst = 1'b1; coll_in = 1'b1; cyc();
        check_eq("auto_rst",
                 32'({state, ball_run, ball_serve, det_clear, lives, game_over}), 32'd0);
        rst = 1'b0;
        idle_inputs();
        cyc();
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter LIVES_INIT, default 3, lives loaded at game start (1..3).
REQ-002 Parameter BOTTOM_Y, default 756, ball_y value at or beyond which the ball is lost.
REQ-003 Parameter SERVE_FRAMES, default 60, frame count for auto-serve (used only with SERVE_AUTO_EN).
REQ-004 pclk  input  1  system clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 frame_tick  input  1  one-pclk pulse per video frame.
REQ-007 start_btn  input  1  debounced player button, level.
REQ-008 ball_y  input  12  current ball top coordinate.
REQ-009 coll_in  input  1  collision indication from the collision detector, level.
REQ-010 blocks_in  input  16  destroyed-tile bitmap from the collision detector; bit n set = tile n gone.
REQ-011 state  output  3  current state encoding.
REQ-012 ball_run  output  1  ball motion enable.
REQ-013 ball_serve  output  1  one-cycle pulse: reposition ball at the paddle.
REQ-014 det_clear  output  1  one-cycle pulse: clear the collision detector's tile bitmap and tile hit counters.
REQ-015 lives  output  2  remaining lives.
REQ-016 score  output  16  score, saturating.
REQ-017 game_over  output  1  high while in OVER.

Function
REQ-018 The block SHALL implement states IDLE=0, SERVE=1, PLAY=2, MISS=3, CLEAR=4, OVER=5; codes 6-7 SHALL return to IDLE on the next cycle.
REQ-019 All outputs SHALL be registered; each output changes 1 pclk after the event that causes it.
REQ-020 start_btn SHALL be registered once; btn_edge = start_btn AND NOT previous start_btn; coll_edge is formed the same way from coll_in.
REQ-021 IDLE: on btn_edge, lives is set to LIVES_INIT, score is set to 0, det_clear pulses and the state goes to SERVE.
REQ-022 On every entry into SERVE, ball_serve SHALL pulse for exactly one cycle and ball_run SHALL be 0 throughout SERVE.
REQ-023 SERVE exits to PLAY on btn_edge; the btn_edge that caused entry from IDLE or OVER SHALL NOT count as the serve press.
REQ-024 PLAY: ball_run=1; each coll_edge SHALL add 1 to score, saturating at 16'hFFFF.
REQ-025 PLAY: if blocks_in==16'hFFFF the state goes to CLEAR; otherwise, if ball_y>=BOTTOM_Y (unsigned 12-bit compare), the state goes to MISS; CLEAR has priority when both hold.
REQ-026 A coll_edge coinciding with the PLAY exit SHALL still be scored.
REQ-027 MISS lasts one cycle with ball_run=0; lives decrements by 1; if lives was 1, the next state is OVER with lives=0, otherwise it is SERVE.
REQ-028 CLEAR lasts one cycle: det_clear pulses, score += 16 (saturating), lives are unchanged, and the next state is SERVE.
REQ-029 OVER: game_over=1 and ball_run=0; score and lives are held; on btn_edge the state goes to IDLE.
REQ-030 lives SHALL never underflow below 0 and score SHALL never wrap.

Reset
REQ-031 While rst=1 at a pclk edge: state=IDLE, ball_run=0, ball_serve=0, det_clear=0, lives=0, score=0, game_over=0, both edge registers=0.
REQ-032 Reset asserted mid-game SHALL abort to IDLE with the values above on the next cycle, overriding any event in the same cycle.
REQ-033 After reset, a button held high SHALL NOT produce btn_edge until it has been released and pressed again.

Configuration
REQ-034 Macro SERVE_AUTO_EN: when defined, SERVE also exits to PLAY after SERVE_FRAMES frame_tick pulses counted from SERVE entry (8-bit counter, cleared on entry), or earlier on btn_edge.
REQ-035 When SERVE_AUTO_EN is undefined, the frame counter SHALL NOT exist, frame_tick is ignored, and SERVE exits only on btn_edge.

Verification
REQ-036 Reset, then press start -> state=1, lives=3, score=0, single det_clear and single ball_serve pulse; press again -> state=2, ball_run=1.
REQ-037 In PLAY, 5 separate coll_in pulses, one held high for 10 cycles -> score=5.
REQ-038 In PLAY with lives=3, set ball_y=756 -> MISS for 1 cycle, lives=2, state=1; repeat twice more -> lives=0, state=5, game_over=1.
REQ-039 In PLAY, blocks_in=16'hFFFF together with ball_y=800 -> CLEAR, score +16, lives unchanged, det_clear pulse, state=1.
REQ-040 Preload score=16'hFFF5 and clear the level -> score=16'hFFFF.
REQ-041 With SERVE_AUTO_EN defined, enter SERVE and apply 60 frame_ticks without pressing start -> PLAY begins 1 cycle after the 60th tick; assert rst mid-PLAY -> all outputs at reset values.
